axi_lite_usr_arbiter: RTL and testbench

//  Shares one AXI4-Lite master user interface (usr_* ports) between NUM_REQ requesters.

---
 rtl/axi_lite_arb_pkg.sv | 19 +
 rtl/axi_lite_usr_arbiter_if.sv | 70 +++++++
 rtl/axi_lite_rr_arb.sv | 39 +++
 rtl/axi_lite_usr_arbiter.sv | 138 +++++++++++++
 tb/tb_axi_lite_usr_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite user-port arbiter.
// Holds the per-path FSM state encoding, response codes and the pointer-width helper.
package axi_lite_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A single requester still needs a 1-bit pointer so every vector stays non-empty.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_usr_arbiter_if.sv
// Requester-side and master-side signals of the arbiter, bundled as one interface.
// slave = arbiter view, master = requesters plus AXI4-Lite master driving it.
interface axi_lite_usr_arbiter_if
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  // Handshake: a requester raises *_valid and holds it with its payload until
  // it sees its one-hot *_ready pulse; completion is a one-cycle *_done pulse
  // carrying *_resp (and req_rd_data for reads). usr_*_req are single-cycle
  // requests to the master, whose usr_*_done pulses complete them.
  logic [NUM_REQ-1:0]              req_wr_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_wr_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wr_data;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wr_strb;
  logic [NUM_REQ-1:0]              req_wr_ready;
  logic [NUM_REQ-1:0]              req_wr_done;
  logic [1:0]                      req_wr_resp;

  logic [NUM_REQ-1:0]              req_rd_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_rd_addr;
  logic [NUM_REQ-1:0]              req_rd_ready;
  logic [NUM_REQ-1:0]              req_rd_done;
  logic [1:0]                      req_rd_resp;
  logic [DATA_WIDTH-1:0]           req_rd_data;

  logic                            usr_write_req;
  logic [ADDR_WIDTH-1:0]           usr_awaddr;
  logic [DATA_WIDTH-1:0]           usr_wdata;
  logic [DATA_WIDTH/8-1:0]         usr_wstrb;
  logic                            usr_wr_done;
  logic [1:0]                      usr_wr_resp;

  logic                            usr_read_req;
  logic [ADDR_WIDTH-1:0]           usr_araddr;
  logic                            usr_rd_done;
  logic [1:0]                      usr_rd_resp;
  logic [DATA_WIDTH-1:0]           usr_rdata;

  arb_state_e                      dbg_wr_state;
  arb_state_e                      dbg_rd_state;

  modport slave (
    input  req_wr_valid, req_wr_addr, req_wr_data, req_wr_strb,
    output req_wr_ready, req_wr_done, req_wr_resp,
    input  req_rd_valid, req_rd_addr,
    output req_rd_ready, req_rd_done, req_rd_resp, req_rd_data,
    output usr_write_req, usr_awaddr, usr_wdata, usr_wstrb,
    input  usr_wr_done, usr_wr_resp,
    output usr_read_req, usr_araddr,
    input  usr_rd_done, usr_rd_resp, usr_rdata,
    output dbg_wr_state, dbg_rd_state
  );

  modport master (
    output req_wr_valid, req_wr_addr, req_wr_data, req_wr_strb,
    input  req_wr_ready, req_wr_done, req_wr_resp,
    output req_rd_valid, req_rd_addr,
    input  req_rd_ready, req_rd_done, req_rd_resp, req_rd_data,
    input  usr_write_req, usr_awaddr, usr_wdata, usr_wstrb,
    output usr_wr_done, usr_wr_resp,
    input  usr_read_req, usr_araddr,
    output usr_rd_done, usr_rd_resp, usr_rdata,
    input  dbg_wr_state, dbg_rd_state
  );

endinterface

// File: rtl/axi_lite_rr_arb.sv
// Combinational round-robin picker: first valid at or after ptr_i, wrapping.
// Returns the winner both one-hot and as an index.
module axi_lite_rr_arb #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic          any_hi;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  // Scan downward so the lowest matching index wins; "hi" covers indices at or
  // above the pointer, "lo" is the wrapped fallback.
  always_comb begin
    any_o  = 1'b0;
    any_hi = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        any_o  = 1'b1;
        lo_idx = PW'(i);
        if (PW'(i) >= ptr_i) begin
          any_hi = 1'b1;
          hi_idx = PW'(i);
        end
      end
    end
    idx_o   = any_hi ? hi_idx : lo_idx;
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/axi_lite_usr_arbiter.sv
// Shares one AXI4-Lite master user port between NUM_REQ requesters, with
// independent round-robin write and read paths, one transaction in flight each.
module axi_lite_usr_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESET,
  axi_lite_usr_arbiter_if.slave  bus
);

  localparam int PW = ptr_width(NUM_REQ);
  localparam int SW = DATA_WIDTH / 8;

  arb_state_e              wr_state_q, wr_state_d, rd_state_q, rd_state_d;
  logic [PW-1:0]           wr_ptr_q, wr_idx_q, wr_pick, rd_ptr_q, rd_idx_q, rd_pick;
  logic [NUM_REQ-1:0]      wr_gnt_q, wr_grant, rd_gnt_q, rd_grant;
  logic                    wr_any, rd_any;
  logic [NUM_REQ-1:0]      wr_done_q, rd_done_q;
  logic [1:0]              wr_resp_q, rd_resp_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_sel, araddr_q, araddr_sel;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_sel, rdata_q;
  logic [SW-1:0]           wstrb_q, wstrb_sel;

  axi_lite_rr_arb #(.N(NUM_REQ), .PW(PW)) u_wr_arb (
    .valid_i (bus.req_wr_valid), .ptr_i (wr_ptr_q),
    .grant_o (wr_grant), .idx_o (wr_pick), .any_o (wr_any)
  );

  axi_lite_rr_arb #(.N(NUM_REQ), .PW(PW)) u_rd_arb (
    .valid_i (bus.req_rd_valid), .ptr_i (rd_ptr_q),
    .grant_o (rd_grant), .idx_o (rd_pick), .any_o (rd_any)
  );

  always_comb begin
    awaddr_sel = '0;
    wdata_sel  = '0;
    wstrb_sel  = '0;
    araddr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_grant[i]) begin
        awaddr_sel = bus.req_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_sel  = bus.req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        wstrb_sel  = bus.req_wr_strb[i*SW +: SW];
      end
      if (rd_grant[i]) begin
        araddr_sel = bus.req_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      wr_state_q <= ST_IDLE;
      rd_state_q <= ST_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Completion is only honoured in WAIT; stray master pulses elsewhere are dropped.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      ST_IDLE:  if (wr_any) wr_state_d = ST_ISSUE;
      ST_ISSUE: wr_state_d = ST_WAIT;
      ST_WAIT:  if (bus.usr_wr_done) wr_state_d = ST_IDLE;
      default:  wr_state_d = ST_IDLE;
    endcase
    rd_state_d = rd_state_q;
    case (rd_state_q)
      ST_IDLE:  if (rd_any) rd_state_d = ST_ISSUE;
      ST_ISSUE: rd_state_d = ST_WAIT;
      ST_WAIT:  if (bus.usr_rd_done) rd_state_d = ST_IDLE;
      default:  rd_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      wr_ptr_q  <= '0;  wr_idx_q <= '0;  wr_gnt_q <= '0;
      wr_done_q <= '0;  wr_resp_q <= RESP_OKAY;
      awaddr_q  <= '0;  wdata_q <= '0;   wstrb_q <= '0;
      rd_ptr_q  <= '0;  rd_idx_q <= '0;  rd_gnt_q <= '0;
      rd_done_q <= '0;  rd_resp_q <= RESP_OKAY;
      araddr_q  <= '0;  rdata_q <= '0;
    end else begin
      wr_done_q <= '0;
      rd_done_q <= '0;
      if (wr_state_q == ST_IDLE && wr_any) begin
        wr_gnt_q <= wr_grant;
        wr_idx_q <= wr_pick;
        awaddr_q <= awaddr_sel;
        wdata_q  <= wdata_sel;
        wstrb_q  <= wstrb_sel;
      end
      if (wr_state_q == ST_WAIT && bus.usr_wr_done) begin
        wr_done_q <= wr_gnt_q;
        wr_resp_q <= bus.usr_wr_resp;
        wr_ptr_q  <= (wr_idx_q == PW'(NUM_REQ - 1)) ? '0 : wr_idx_q + 1'b1;
      end
      if (rd_state_q == ST_IDLE && rd_any) begin
        rd_gnt_q <= rd_grant;
        rd_idx_q <= rd_pick;
        araddr_q <= araddr_sel;
      end
      if (rd_state_q == ST_WAIT && bus.usr_rd_done) begin
        rd_done_q <= rd_gnt_q;
        rd_resp_q <= bus.usr_rd_resp;
        rdata_q   <= bus.usr_rdata;
        rd_ptr_q  <= (rd_idx_q == PW'(NUM_REQ - 1)) ? '0 : rd_idx_q + 1'b1;
      end
    end
  end

  assign bus.usr_write_req = (wr_state_q == ST_ISSUE);
  assign bus.req_wr_ready  = (wr_state_q == ST_ISSUE) ? wr_gnt_q : '0;
  assign bus.req_wr_done   = wr_done_q;
  assign bus.req_wr_resp   = wr_resp_q;
  assign bus.usr_awaddr    = awaddr_q;
  assign bus.usr_wdata     = wdata_q;
  assign bus.usr_wstrb     = wstrb_q;

  assign bus.usr_read_req  = (rd_state_q == ST_ISSUE);
  assign bus.req_rd_ready  = (rd_state_q == ST_ISSUE) ? rd_gnt_q : '0;
  assign bus.req_rd_done   = rd_done_q;
  assign bus.req_rd_resp   = rd_resp_q;
  assign bus.req_rd_data   = rdata_q;
  assign bus.usr_araddr    = araddr_q;

  assign bus.dbg_wr_state  = wr_state_q;
  assign bus.dbg_rd_state  = rd_state_q;

endmodule

// File: tb/tb_axi_lite_usr_arbiter.sv
// Directed bench for axi_lite_usr_arbiter: N=4, requesters and master driven by hand,
// expected grants, payloads and responses written out per step.
module tb_axi_lite_usr_arbiter;
  import axi_lite_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total    = 0;
  int pass_cnt = 0;

  logic [AW-1:0] wa [N] = '{32'h0000_0100, 32'h0000_0010, 32'h0000_0108, 32'h0000_010C};
  logic [DW-1:0] wd [N] = '{32'h1111_0000, 32'hDEAD_BEEF, 32'h2222_0002, 32'h3333_0003};
  logic [3:0]    ws [N] = '{4'h1, 4'hF, 4'h3, 4'hC};
  logic [AW-1:0] ra [N] = '{32'h0000_0200, 32'h0000_0204, 32'h0000_0020, 32'h0000_020C};

  axi_lite_usr_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_usr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .bus          (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Entered with the write FSM idle and the wanted valids already set; runs a full
  // write through ISSUE, wait_n extra WAIT cycles, then a master completion.
  task automatic wr_txn(input int g, input logic [1:0] resp, input bit drop, input int wait_n);
    logic [N-1:0] oh;
    oh = N'(1) << g;
    tick();
    chk("wr_issue_req", bus.usr_write_req, 1'b1);
    chk("wr_ready", bus.req_wr_ready, oh);
    chk("wr_awaddr", bus.usr_awaddr, wa[g]);
    chk("wr_wdata", bus.usr_wdata, wd[g]);
    chk("wr_wstrb", bus.usr_wstrb, ws[g]);
    if (drop) bus.req_wr_valid = bus.req_wr_valid & ~oh;
    tick();
    chk("wr_wait_req", bus.usr_write_req, 1'b0);
    chk("wr_wait_ready", bus.req_wr_ready, 4'b0000);
    for (int k = 0; k < wait_n; k++) begin
      tick();
      chk("wr_wait_nodone", bus.req_wr_done, 4'b0000);
      chk("wr_wait_state", bus.dbg_wr_state, ST_WAIT);
    end
    bus.usr_wr_done = 1'b1;
    bus.usr_wr_resp = resp;
    tick();
    bus.usr_wr_done = 1'b0;
    bus.usr_wr_resp = RESP_OKAY;
    chk("wr_done", bus.req_wr_done, oh);
    chk("wr_resp", bus.req_wr_resp, resp);
  endtask

  task automatic load_payloads();
    bus.req_wr_addr = {wa[3], wa[2], wa[1], wa[0]};
    bus.req_wr_data = {wd[3], wd[2], wd[1], wd[0]};
    bus.req_wr_strb = {ws[3], ws[2], ws[1], ws[0]};
    bus.req_rd_addr = {ra[3], ra[2], ra[1], ra[0]};
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.req_wr_valid = '0;
    bus.req_rd_valid = '0;
    bus.usr_wr_done  = 1'b0;
    bus.usr_wr_resp  = 2'b00;
    bus.usr_rd_done  = 1'b0;
    bus.usr_rd_resp  = 2'b00;
    bus.usr_rdata    = '0;
    load_payloads();

    // Reset state
    repeat (2) tick();
    chk("rst_wr_req", bus.usr_write_req, 1'b0);
    chk("rst_wr_ready", bus.req_wr_ready, 4'b0000);
    chk("rst_rd_done", bus.req_rd_done, 4'b0000);
    chk("rst_awaddr", bus.usr_awaddr, 32'h0);
    chk("rst_rd_data", bus.req_rd_data, 32'h0);
    chk("rst_wr_state", bus.dbg_wr_state, ST_IDLE);
    rst = 1'b0;
    tick();

    // All four writers held high: 0,1,2,3,0 (ptr ends at 1)
    bus.req_wr_valid = 4'b1111;
    wr_txn(0, RESP_OKAY, 1'b0, 0);
    wr_txn(1, RESP_OKAY, 1'b0, 0);
    wr_txn(2, RESP_OKAY, 1'b0, 0);
    wr_txn(3, RESP_OKAY, 1'b0, 0);
    wr_txn(0, RESP_OKAY, 1'b0, 0);
    bus.req_wr_valid = '0;
    tick();
    chk("rr_idle_req", bus.usr_write_req, 1'b0);
    chk("rr_done_once", bus.req_wr_done, 4'b0000);

    // Single write from requester 1: addr 0x10, DEADBEEF, strb F, OKAY (ptr ends at 2)
    bus.req_wr_valid = 4'b0010;
    wr_txn(1, RESP_OKAY, 1'b1, 0);
    tick();
    chk("w1_done_pulse", bus.req_wr_done, 4'b0000);

    // Concurrent write from 0 and read from 2 at 0x20
    bus.req_wr_valid = 4'b0001;
    bus.req_rd_valid = 4'b0100;
    tick();
    chk("cc_wr_ready", bus.req_wr_ready, 4'b0001);
    chk("cc_rd_ready", bus.req_rd_ready, 4'b0100);
    chk("cc_rd_req", bus.usr_read_req, 1'b1);
    chk("cc_araddr", bus.usr_araddr, 32'h0000_0020);
    bus.req_wr_valid = '0;
    bus.req_rd_valid = '0;
    tick();
    chk("cc_rd_wait_req", bus.usr_read_req, 1'b0);
    bus.usr_rd_done = 1'b1;
    bus.usr_rdata   = 32'hCAFE_0001;
    bus.usr_rd_resp = RESP_OKAY;
    tick();
    bus.usr_rd_done = 1'b0;
    bus.usr_rdata   = 32'h5555_5555;
    chk("cc_rd_done", bus.req_rd_done, 4'b0100);
    chk("cc_rd_data", bus.req_rd_data, 32'hCAFE_0001);
    chk("cc_wr_still_wait", bus.req_wr_done, 4'b0000);
    bus.usr_wr_done = 1'b1;
    tick();
    bus.usr_wr_done = 1'b0;
    chk("cc_wr_done", bus.req_wr_done, 4'b0001);
    chk("cc_rd_done_once", bus.req_rd_done, 4'b0000);

    // Stray master completion while idle is ignored
    bus.usr_wr_done = 1'b1;
    bus.usr_wr_resp = RESP_SLVERR;
    tick();
    bus.usr_wr_done = 1'b0;
    bus.usr_wr_resp = RESP_OKAY;
    tick();
    chk("stray_no_done", bus.req_wr_done, 4'b0000);
    chk("stray_state", bus.dbg_wr_state, ST_IDLE);

    // Master timeout: requester 3 gets SLVERR after a long WAIT; a valid from
    // requester 2 rises and falls meanwhile and must never be issued
    bus.req_wr_valid = 4'b1000;
    tick();
    chk("to_ready", bus.req_wr_ready, 4'b1000);
    bus.req_wr_valid = 4'b0100;
    tick();
    bus.req_wr_valid = 4'b0000;
    repeat (4) tick();
    chk("to_nodone", bus.req_wr_done, 4'b0000);
    bus.usr_wr_done = 1'b1;
    bus.usr_wr_resp = RESP_SLVERR;
    tick();
    bus.usr_wr_done = 1'b0;
    bus.usr_wr_resp = RESP_OKAY;
    chk("to_done", bus.req_wr_done, 4'b1000);
    chk("to_resp", bus.req_wr_resp, RESP_SLVERR);
    chk("to_rd_data_held", bus.req_rd_data, 32'hCAFE_0001);
    bus.req_wr_valid = 4'b0010;
    wr_txn(1, RESP_OKAY, 1'b1, 2);

    // Wrap: last grant 3, then 0 and 2 both request -> 0 then 2
    bus.req_wr_valid = 4'b1000;
    wr_txn(3, RESP_OKAY, 1'b1, 0);
    bus.req_wr_valid = 4'b0101;
    wr_txn(0, RESP_OKAY, 1'b1, 0);
    wr_txn(2, RESP_OKAY, 1'b1, 1);

    // Reset in WAIT on both paths: outputs clear at once, no done pulse,
    // pointers return to 0 (write ptr was 3 before)
    bus.req_wr_valid = 4'b0010;
    bus.req_rd_valid = 4'b0010;
    tick();
    chk("rw_wr_ready", bus.req_wr_ready, 4'b0010);
    chk("rw_rd_ready", bus.req_rd_ready, 4'b0010);
    bus.req_wr_valid = '0;
    bus.req_rd_valid = '0;
    tick();
    chk("rw_wr_state", bus.dbg_wr_state, ST_WAIT);
    bus.usr_wr_done = 1'b1;
    bus.usr_rd_done = 1'b1;
    bus.usr_rdata   = 32'h1234_5678;
    rst = 1'b1;
    #1;
    chk("rw_awaddr_clr", bus.usr_awaddr, 32'h0);
    chk("rw_rd_data_clr", bus.req_rd_data, 32'h0);
    chk("rw_rd_state", bus.dbg_rd_state, ST_IDLE);
    tick();
    chk("rw_no_wr_done", bus.req_wr_done, 4'b0000);
    chk("rw_no_rd_done", bus.req_rd_done, 4'b0000);
    bus.usr_wr_done = 1'b0;
    bus.usr_rd_done = 1'b0;
    rst = 1'b0;
    tick();
    chk("rw_post_wr_done", bus.req_wr_done, 4'b0000);
    bus.req_wr_valid = 4'b1001;
    wr_txn(0, RESP_OKAY, 1'b1, 0);
    bus.req_wr_valid = '0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
